// File: rtl/fp32_add_sched.sv
// fp32_add_sched
// Round-robin scheduler that lets NREQ requesters share one external
// combinational fp32 adder. Operands pass through a two-stage pipeline:
// S1 holds the operand pair driven to the adder, and S2 captures the sum
// for the consumer. Results and operands are passed through untouched.
module fp32_add_sched #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*32-1:0]       req_a,
    input  logic [NREQ*32-1:0]       req_b,
    output logic [31:0]              add_a,
    output logic [31:0]              add_b,
    input  logic [31:0]              add_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [CNTW-1:0]          done_count
);

    localparam int IDW = $clog2(NREQ);

    logic            s1_valid;
    logic [31:0]     s1_a;
    logic [31:0]     s1_b;
    logic [IDW-1:0]  s1_id;
    logic [IDW-1:0]  ptr;

    logic            s2_free;
    logic            s1_free;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan_idx [NREQ];
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            handshake;

    // The adder always sees the S1 operand registers, which only change on a handshake
    assign add_a = s1_a;
    assign add_b = s1_b;

    // S2 can take a new result when empty or being drained; S1 moves whenever S2 can
    assign s2_free   = !rsp_valid || rsp_ready;
    assign s1_free   = !s1_valid || s2_free;
    assign handshake = |(req_valid & req_ready);

    // Requester indices in priority order, starting at the round-robin pointer
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            scan_idx[k] = IDW'((int'(ptr) + k) % NREQ);
        end
    end

    // Pick the first valid requester at or after the pointer
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[scan_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[k];
            end
        end
    end

    // Operand pair of the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*32 +: 32];
                sel_b = req_b[i*32 +: 32];
            end
        end
    end

    // One-hot ready on the winner, only when S1 has room and never during reset
    always_comb begin
        req_ready = '0;
        if (!rst && s1_free && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Pipeline registers, arbitration pointer and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            ptr        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            done_count <= '0;
        end else begin
            if (s2_free) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_result <= add_result;
                    rsp_id     <= s1_id;
                end
            end

            if (handshake) begin
                s1_valid <= 1'b1;
                s1_a     <= sel_a;
                s1_b     <= sel_b;
                s1_id    <= grant_idx;
                ptr      <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end

            if (rsp_valid && rsp_ready) begin
                done_count <= done_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp32_add_sched.sv
// tb_fp32_add_sched
// Randomised scoreboard bench for fp32_add_sched. The request side predicts
// grants from a round-robin model and a two-entry occupancy count, pushing
// expected sums; the monitor pops and compares whenever a response shows up.
module tb_fp32_add_sched;

    localparam int NREQ = 4;
    localparam int CNTW = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [31:0]          add_a;
    logic [31:0]          add_b;
    logic [31:0]          add_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_result;
    logic [1:0]           rsp_id;
    logic [CNTW-1:0]      done_count;

    typedef struct {
        logic [31:0] res;
        int          id;
        int          cyc;
    } entry_t;

    entry_t         sb[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             mptr = 0;
    int             pops = 0;
    int             grant_cnt[NREQ];
    logic [CNTW-1:0] mdone = '0;

    fp32_add_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .done_count (done_count)
    );

    // Normal fp32 to real (zero/denormal flushed to 0.0)
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // Real to fp32 by truncating the mantissa; operands keep results in normal range
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        e = 8'($urandom_range(150, 100));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // External adder stand-in
    assign add_result = fp_add(add_a, add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy, input logic rst_in);
        rst       = rst_in;
        req_valid = valid;
        rsp_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = rand_op();
            req_b[i*32 +: 32] = rand_op();
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Request-side model: predicts req_ready and records accepted operations
    initial begin
        int          n;
        int          g;
        logic [NREQ-1:0] exp_ready;
        entry_t      e;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("ready_in_reset", 32'(req_ready), 32'h0);
                sb.delete();
                mptr = 0;
            end else begin
                n = sb.size();
                g = -1;
                exp_ready = '0;
                if (n < 2 || rsp_ready) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
                    end
                end
                if (g >= 0) exp_ready[g] = 1'b1;
                checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
                if (g >= 0) begin
                    e.res = fp_add(req_a[g*32 +: 32], req_b[g*32 +: 32]);
                    e.id  = g;
                    e.cyc = cyc;
                    sb.push_back(e);
                    mptr = (g + 1) % NREQ;
                    grant_cnt[g]++;
                end
            end
        end
    end

    // Response monitor: head of the scoreboard must appear exactly two edges after its handshake
    initial begin
        logic exp_v;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mdone = '0;
            end else begin
                exp_v = (sb.size() > 0) && (cyc >= sb[0].cyc + 2);
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_v));
                checkOutput("done_count", 32'(done_count), 32'(mdone));
                if (rsp_valid && exp_v) begin
                    checkOutput("rsp_result", rsp_result, sb[0].res);
                    checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                end
                if (rsp_valid && rsp_ready && sb.size() > 0) begin
                    void'(sb.pop_front());
                    mdone = mdone + CNTW'(1);
                    pops++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Directed phases followed by random traffic
    initial begin
        int pops0;
        for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
        applyStimulus(4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) nextCycle();

        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_done_count", 32'(done_count), 32'h0);
        checkOutput("reset_add_a", add_a, 32'h0);
        checkOutput("reset_add_b", add_b, 32'h0);
        checkOutput("reset_rsp_result", rsp_result, 32'h0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'h0);

        // Single operation: 1.0 + 2.0 from requester 0
        applyStimulus(4'b0001, 1'b1, 1'b0);
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        nextCycle();
        checkOutput("single_valid", 32'(rsp_valid), 32'h1);
        checkOutput("single_result", rsp_result, 32'h40400000);
        checkOutput("single_id", 32'(rsp_id), 32'h0);
        nextCycle();
        checkOutput("single_done", 32'(done_count), 32'h1);
        for (int i = 0; i < 2; i++) nextCycle();

        // Fairness: everyone requests continuously
        for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'hF, 1'b1, 1'b0);
            nextCycle();
        end
        applyStimulus(4'h0, 1'b1, 1'b0);
        for (int i = 0; i < NREQ; i++) checkOutput($sformatf("fair_grants_%0d", i), 32'(grant_cnt[i]), 32'd4);
        for (int i = 0; i < 3; i++) nextCycle();

        // Backpressure with three requesters pending
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0111, 1'b0, 1'b0);
            nextCycle();
        end
        checkOutput("bp_req_ready", 32'(req_ready), 32'h0);
        checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("bp_inflight", 32'(sb.size()), 32'd2);
        if (sb.size() > 0) checkOutput("bp_held_result", rsp_result, sb[0].res);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            nextCycle();
        end
        checkOutput("bp_drained", 32'(sb.size()), 32'd0);

        // Streaming from requester 2
        pops0 = pops;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0100, 1'b1, 1'b0);
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            nextCycle();
        end
        checkOutput("stream_count", 32'(pops - pops0), 32'd8);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom_range(15, 0)), ($urandom_range(3, 0) != 0), 1'b0);
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            nextCycle();
        end
        checkOutput("random_drained", 32'(sb.size()), 32'd0);

        // Reset while both stages are full
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'hF, 1'b0, 1'b0);
            nextCycle();
        end
        checkOutput("mid_full", 32'(sb.size()), 32'd2);
        applyStimulus(4'hF, 1'b1, 1'b1);
        nextCycle();
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("mid_done_count", 32'(done_count), 32'h0);
        applyStimulus(4'hF, 1'b1, 1'b0);
        #1;
        checkOutput("mid_first_grant", 32'(req_ready), 32'h1);
        for (int i = 0; i < 6; i++) nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            nextCycle();
        end

        // Counter wrap: 17 responses into a 4-bit counter
        applyStimulus(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) nextCycle();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(4'b0001, 1'b1, 1'b0);
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            nextCycle();
        end
        checkOutput("wrap_done_count", 32'(done_count), 32'd1);
        checkOutput("final_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
